regfile_test_driver: RTL
========================

Name: regfile_test_driver

Overview:
- Initiator for the regfile test-mode port. This is the stimulus side of the `test` mux path in front of `regfile`.
- On `start`, it takes the port with `test=1` and writes a deterministic pattern into every register. It then reads each register back through both read ports A and B and compares, and reports pass/fail, error count and first failing register.
- Sits in the top-level test harness. It drives the `t_ctrl_*` / `t_data_writeReg` inputs and consumes `t_data_readRegA` / `t_data_readRegB`.

Parameters:
- NUM_REGS, 32: registers swept, indices 0..NUM_REGS-1; power of two, at most 32.
- SEED, 32'hA5C3_0F69: base data pattern.
- WR_HOLD, 4: cycles write controls are held stable per write; at least 1, covers a divided regfile_clock.
- RD_WAIT, 2: cycles between driving read addresses and sampling read data; at least 1.

Ports:
- clock  in  1  driver clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; ignored unless idle
- test  out  1  regfile port select; 1 while busy
- t_ctrl_writeEnable  out  1  regfile write enable
- t_ctrl_writeReg  out  5  write address
- t_ctrl_readRegA  out  5  read address, port A
- t_ctrl_readRegB  out  5  read address, port B
- t_data_writeReg  out  32  write data
- t_data_readRegA  in  32  read data, port A
- t_data_readRegB  in  32  read data, port B
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep
- pass  out  1  sticky result, valid from done until next start
- err_count  out  8  mismatches in the last sweep; saturates at 255
- first_fail_reg  out  5  register of the first mismatch; 0 if none
- fail_data_a  out  32  port A data at first mismatch (feature)
- fail_data_b  out  32  port B data at first mismatch (feature)

Behaviour:
- Reset (async assert, sync deassert into IDLE) drives every output to 0, including pass.
- Pattern for register i in phase p: pat(i,p) = (SEED ^ {27'b0,i} ^ {i,27'b0}) ^ {32{p}}. Phase 0 writes the true pattern; phase 1 writes the inverted pattern.
- Expected read value: 0 for register 0, pat(i,p) otherwise. Both ports A and B must match.
- FSM states: IDLE, WRITE, RD_ADDR, RD_WAIT, CHECK, NEXT, DONE.
- IDLE: on start, clear err_count, first_fail_reg and fail_data; set test=1 and busy=1; set i=0, p=0; go to WRITE.
- WRITE:
  - Drive we=1, writeReg=i, data=pat(i,p) for WR_HOLD cycles. Register 0 is also written, so its hardwired zero is exercised.
  - Deassert we one cycle before the address or data change, so the next write cannot corrupt this one.
  - Advance i. After NUM_REGS-1, set i=0 and go to RD_ADDR.
- RD_ADDR: readRegA=i, readRegB=(i+NUM_REGS/2) mod NUM_REGS, so the two ports read different registers concurrently.
- RD_WAIT: hold the addresses for RD_WAIT cycles.
- CHECK:
  - Sample both read ports and compare each against its own register's expected value.
  - Any mismatch increments err_count once per port (saturating at 255).
  - On the first mismatch, latch first_fail_reg as port A's register if A failed, else B's.
- NEXT:
  - If i < NUM_REGS-1, increment i and go to RD_ADDR.
  - Else if p=0, set p=1, i=0 and go to WRITE.
  - Else go to DONE.
- DONE: pass = (err_count==0); pulse done for one cycle; drop test and busy in the same cycle; return to IDLE.
- start while busy is ignored.
- reset mid-sweep aborts immediately: test=0, we=0, no done pulse.
- Total latency: 2·NUM_REGS·(WR_HOLD+1) + 2·NUM_REGS·(RD_WAIT+3) + 1 cycles. Bench checks this exact count.

Optional Feature:
- REGFILE_TEST_TRACE_EN defined: fail_data_a and fail_data_b latch the raw port data on the first mismatching CHECK and hold it until the next start.
- Undefined: both ports are tied to 0, no capture flops are built; all other behaviour is identical.

Decomposition:
- Package regfile_test_pkg holds:
  - state enum typedef;
  - REG_ADDR_W=5 and DATA_W=32;
  - a pattern function pat(i,p).
- One sub-module, regfile_test_checker: combinational expected-value compare for ports A and B, zero rule for register 0, result registered in CHECK. The FSM and counters stay in the top.

Test Plan:
- Healthy regfile model, start pulse: done after the computed latency; pass=1, err_count=0, first_fail_reg=0; test=1 throughout busy.
- Regfile model with register 7 bit 3 stuck-at-0: pass=0; first_fail_reg=7; err_count=2 for that register (each register is read on both ports over the sweep); fail_data_a has bit 3 clear when the feature is on.
- Model whose register 0 stores writes: first_fail_reg=0; err_count≥2 (port A i=0, port B i=NUM_REGS/2).
- reset deasserted then asserted at cycle 50 of the sweep: outputs immediately 0, no done; a new start runs a clean full sweep.
- start pulsed again while busy at cycle 10: ignored; single done; sweep length unchanged.
- WR_HOLD=1, RD_WAIT=1, NUM_REGS=8: latency = 2·8·2 + 2·8·4 + 1 = 97 cycles; pass=1.

Source files
------------

// File: rtl/regfile_test_pkg.sv
// regfile_test_pkg: shared widths, FSM states and sweep pattern for the regfile test driver
// Contents: REG_ADDR_W, DATA_W, state_t, pat(seed, i, p).
package regfile_test_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_RD_ADDR, ST_RD_WAIT, ST_CHECK, ST_NEXT, ST_DONE} state_t;
    function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] seed, input logic [REG_ADDR_W-1:0] i, input logic p);
        return seed ^ {27'b0, i} ^ {i, 27'b0} ^ {DATA_W{p}};
    endfunction
endpackage

// File: rtl/regfile_test_checker.sv
// regfile_test_checker: combinational expected-value compare for read ports A and B
// Ports: phase (pattern phase), addr_a/addr_b (registers being read),
//        data_a/data_b (raw read data), miss_a/miss_b (mismatch flags).
// Register 0 is hardwired to zero, so its expected value is always 0.
module regfile_test_checker import regfile_test_pkg::*; #(
    parameter logic [DATA_W-1:0] SEED = 32'hA5C3_0F69
) (
    input  logic                  phase,
    input  logic [REG_ADDR_W-1:0] addr_a,
    input  logic [REG_ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0]     data_a,
    input  logic [DATA_W-1:0]     data_b,
    output logic                  miss_a,
    output logic                  miss_b
);
    logic [DATA_W-1:0] exp_a, exp_b;
    assign exp_a = addr_a == '0 ? '0 : pat(SEED, addr_a, phase);
    assign exp_b = addr_b == '0 ? '0 : pat(SEED, addr_b, phase);
    assign miss_a = data_a != exp_a;
    assign miss_b = data_b != exp_b;
endmodule

// File: rtl/regfile_test_driver.sv
// regfile_test_driver: write/read-back sweep of the regfile through its test-mode port
// Ports: clock, reset (async active-low), start (pulse, ignored unless idle);
//        test/t_ctrl_*/t_data_writeReg drive the regfile test port, t_data_readRegA/B return data;
//        busy, done (pulse), pass (sticky), err_count (saturating), first_fail_reg;
//        fail_data_a/b hold port data at the first mismatch when REGFILE_TEST_TRACE_EN is defined, else 0.
// Every output is a register; done, pass, test and busy all change on the edge leaving DONE.
module regfile_test_driver import regfile_test_pkg::*; #(
    parameter int NUM_REGS = 32,
    parameter logic [DATA_W-1:0] SEED = 32'hA5C3_0F69,
    parameter int WR_HOLD = 4,
    parameter int RD_WAIT = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  test,
    output logic                  t_ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] t_ctrl_writeReg,
    output logic [REG_ADDR_W-1:0] t_ctrl_readRegA,
    output logic [REG_ADDR_W-1:0] t_ctrl_readRegB,
    output logic [DATA_W-1:0]     t_data_writeReg,
    input  logic [DATA_W-1:0]     t_data_readRegA,
    input  logic [DATA_W-1:0]     t_data_readRegB,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_count,
    output logic [REG_ADDR_W-1:0] first_fail_reg,
    output logic [DATA_W-1:0]     fail_data_a,
    output logic [DATA_W-1:0]     fail_data_b
);
    localparam logic [REG_ADDR_W-1:0] LAST = REG_ADDR_W'(NUM_REGS - 1);
    localparam logic [REG_ADDR_W-1:0] HALF = REG_ADDR_W'(NUM_REGS / 2);
    localparam logic [15:0] WH_LAST = 16'(WR_HOLD - 1);
    localparam logic [15:0] WH_END = 16'(WR_HOLD);
    localparam logic [15:0] RW_LAST = 16'(RD_WAIT - 1);
    state_t state;
    logic [REG_ADDR_W-1:0] idx;
    logic phase;
    logic [15:0] cnt;
    logic miss_a, miss_b;
    logic [8:0] err_sum;
    assign err_sum = {1'b0, err_count} + {8'b0, miss_a} + {8'b0, miss_b};
    regfile_test_checker #(.SEED(SEED)) u_checker (
        .phase (phase),
        .addr_a(t_ctrl_readRegA),
        .addr_b(t_ctrl_readRegB),
        .data_a(t_data_readRegA),
        .data_b(t_data_readRegB),
        .miss_a(miss_a),
        .miss_b(miss_b)
    );
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            idx <= '0;
            phase <= 1'b0;
            cnt <= '0;
            test <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            t_ctrl_writeEnable <= 1'b0;
            t_ctrl_writeReg <= '0;
            t_ctrl_readRegA <= '0;
            t_ctrl_readRegB <= '0;
            t_data_writeReg <= '0;
            err_count <= '0;
            first_fail_reg <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    err_count <= '0;
                    first_fail_reg <= '0;
                    pass <= 1'b0;
                    test <= 1'b1;
                    busy <= 1'b1;
                    idx <= '0;
                    phase <= 1'b0;
                    cnt <= '0;
                    t_ctrl_writeEnable <= 1'b1;
                    t_ctrl_writeReg <= '0;
                    t_data_writeReg <= pat(SEED, '0, 1'b0);
                    state <= ST_WRITE;
                end
                // we high for WR_HOLD cycles, then one quiet cycle before address/data move on
                ST_WRITE: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == WH_LAST) t_ctrl_writeEnable <= 1'b0;
                    if (cnt == WH_END) begin
                        cnt <= '0;
                        if (idx == LAST) begin
                            idx <= '0;
                            state <= ST_RD_ADDR;
                        end else begin
                            idx <= idx + 1'b1;
                            t_ctrl_writeEnable <= 1'b1;
                            t_ctrl_writeReg <= idx + 1'b1;
                            t_data_writeReg <= pat(SEED, idx + 1'b1, phase);
                        end
                    end
                end
                ST_RD_ADDR: begin
                    t_ctrl_readRegA <= idx;
                    t_ctrl_readRegB <= (idx + HALF) & LAST;
                    cnt <= '0;
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == RW_LAST) state <= ST_CHECK;
                end
                // err_count==0 doubles as "no mismatch seen yet" since it saturates, never wraps
                ST_CHECK: begin
                    err_count <= err_sum > 9'd255 ? 8'hFF : err_sum[7:0];
                    if ((miss_a | miss_b) && err_count == 8'd0) first_fail_reg <= miss_a ? t_ctrl_readRegA : t_ctrl_readRegB;
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (idx != LAST) begin
                        idx <= idx + 1'b1;
                        state <= ST_RD_ADDR;
                    end else if (!phase) begin
                        phase <= 1'b1;
                        idx <= '0;
                        cnt <= '0;
                        t_ctrl_writeEnable <= 1'b1;
                        t_ctrl_writeReg <= '0;
                        t_data_writeReg <= pat(SEED, '0, 1'b1);
                        state <= ST_WRITE;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    pass <= err_count == 8'd0;
                    done <= 1'b1;
                    test <= 1'b0;
                    busy <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`ifdef REGFILE_TEST_TRACE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fail_data_a <= '0;
            fail_data_b <= '0;
        end else if (state == ST_IDLE && start) begin
            fail_data_a <= '0;
            fail_data_b <= '0;
        end else if (state == ST_CHECK && (miss_a | miss_b) && err_count == 8'd0) begin
            fail_data_a <= t_data_readRegA;
            fail_data_b <= t_data_readRegB;
        end
    end
`else
    assign fail_data_a = '0;
    assign fail_data_b = '0;
`endif
endmodule
